// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one valid/ready counter port between NREQ requesters.
// Serialises transactions, pulses req_ready to the winner, and aborts stuck ones on timeout.
module counter_arbiter #(
  parameter int BITS    = 32,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [4*NREQ-1:0]      req_wstrb,
  input  logic [BITS*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic                   req_err,
  output logic [BITS-1:0]        req_rdata,
  output logic                   cnt_valid,
  output logic [3:0]             cnt_wstrb,
  output logic [BITS-1:0]        cnt_wdata,
  input  logic                   cnt_ready,
  input  logic [BITS-1:0]        cnt_rdata,
  output logic                   busy,
  output logic [1:0]             grant
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state;
  logic [1:0]        r_ptr, w_ptr;
  logic [TW-1:0]     r_tcnt, w_tcnt;
  logic [1:0]        r_grant, w_grant;
  logic              r_cnt_valid, w_cnt_valid;
  logic [3:0]        r_wstrb, w_wstrb;
  logic [BITS-1:0]   r_wdata, w_wdata;
  logic [NREQ-1:0]   r_ready, w_ready;
  logic              r_err, w_err;
  logic [BITS-1:0]   r_rdata, w_rdata;

  logic [1:0]        w_win;
  logic [3:0]        w_sel_wstrb;
  logic [BITS-1:0]   w_sel_wdata;
  logic [NREQ-1:0]   w_gnt_oh;
  logic [1:0]        w_ptr_nxt;

  // Search downward from ptr+NREQ-1 to ptr so the requester closest to ptr wins last.
  always_comb begin
    logic [2:0] idx;
    w_win = '0;
    idx   = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = {1'b0, r_ptr} + 3'(k);
      if (idx >= 3'(NREQ)) idx = idx - 3'(NREQ);
      for (int j = 0; j < NREQ; j++)
        if (idx == 3'(j) && req_valid[j]) w_win = 2'(j);
    end
  end

  always_comb begin
    w_sel_wstrb = '0;
    w_sel_wdata = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_win == 2'(j)) begin
        w_sel_wstrb = req_wstrb[4*j +: 4];
        w_sel_wdata = req_wdata[BITS*j +: BITS];
      end
      w_gnt_oh[j] = (r_grant == 2'(j));
    end
  end

  assign w_ptr_nxt = (r_grant == 2'(NREQ-1)) ? 2'd0 : r_grant + 2'd1;

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_tcnt      = r_tcnt;
    w_grant     = r_grant;
    w_cnt_valid = r_cnt_valid;
    w_wstrb     = r_wstrb;
    w_wdata     = r_wdata;
    w_ready     = '0;
    w_err       = 1'b0;
    w_rdata     = r_rdata;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_cnt_valid = 1'b1;
          w_wstrb     = w_sel_wstrb;
          w_wdata     = w_sel_wdata;
          w_grant     = w_win;
          w_state     = S_BUSY;
        end
      end
      S_BUSY: begin
        // A late ack on the final timeout cycle still counts as a normal completion.
        if (cnt_ready) begin
          w_rdata     = cnt_rdata;
          w_ready     = w_gnt_oh;
          w_cnt_valid = 1'b0;
          w_state     = S_DONE;
        end else if (r_tcnt == TW'(TIMEOUT-1)) begin
          w_rdata     = {BITS{1'b1}};
          w_ready     = w_gnt_oh;
          w_err       = 1'b1;
          w_cnt_valid = 1'b0;
          w_state     = S_DONE;
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      S_DONE: begin
        w_ptr   = w_ptr_nxt;
        w_tcnt  = '0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_tcnt      <= '0;
      r_grant     <= '0;
      r_cnt_valid <= 1'b0;
      r_wstrb     <= '0;
      r_wdata     <= '0;
      r_ready     <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state;
      r_ptr       <= w_ptr;
      r_tcnt      <= w_tcnt;
      r_grant     <= w_grant;
      r_cnt_valid <= w_cnt_valid;
      r_wstrb     <= w_wstrb;
      r_wdata     <= w_wdata;
      r_ready     <= w_ready;
      r_err       <= w_err;
      r_rdata     <= w_rdata;
    end
  end

  assign req_ready = r_ready;
  assign req_err   = r_err;
  assign req_rdata = r_rdata;
  assign cnt_valid = r_cnt_valid;
  assign cnt_wstrb = r_wstrb;
  assign cnt_wdata = r_wdata;
  assign busy      = (r_state != S_IDLE);
  assign grant     = r_grant;

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: latency, contention, fairness, timeout, collision, reset.
module tb_counter_arbiter;
  localparam int BITS = 32, NREQ = 2, TIMEOUT = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [4*NREQ-1:0]    req_wstrb;
  logic [BITS*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]      req_ready;
  logic                 req_err;
  logic [BITS-1:0]      req_rdata;
  logic                 cnt_valid;
  logic [3:0]           cnt_wstrb;
  logic [BITS-1:0]      cnt_wdata;
  logic                 cnt_ready;
  logic [BITS-1:0]      cnt_rdata;
  logic                 busy;
  logic [1:0]           grant;

  int total = 0;
  int bad   = 0;

  counter_arbiter #(.BITS(BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .cnt_valid(cnt_valid), .cnt_wstrb(cnt_wstrb), .cnt_wdata(cnt_wdata),
    .cnt_ready(cnt_ready), .cnt_rdata(cnt_rdata),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdy"},  32'(req_ready), 32'd0);
    chk({tag, "_err"},  32'(req_err),   32'd0);
    chk({tag, "_rd"},   req_rdata,      32'd0);
    chk({tag, "_cv"},   32'(cnt_valid), 32'd0);
    chk({tag, "_ws"},   32'(cnt_wstrb), 32'd0);
    chk({tag, "_wd"},   cnt_wdata,      32'd0);
    chk({tag, "_busy"}, 32'(busy),      32'd0);
    chk({tag, "_gnt"},  32'(grant),     32'd0);
  endtask

  // One request from idx, counter acks one cycle after cnt_valid rises.
  task automatic single(input int idx, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rd);
    logic [31:0] oh;
    oh = 32'd1 << idx;
    req_valid = req_valid | NREQ'(oh);
    req_wdata[idx*BITS +: BITS] = wd;
    req_wstrb[idx*4 +: 4] = ws;
    step();                                    // cycle 1
    chk("s_cv1", 32'(cnt_valid), 32'd1);
    chk("s_wd",  cnt_wdata, wd);
    chk("s_ws",  32'(cnt_wstrb), 32'(ws));
    chk("s_gnt", 32'(grant), 32'(idx));
    step();                                    // cycle 2
    chk("s_cv2", 32'(cnt_valid), 32'd1);
    cnt_ready = 1'b1; cnt_rdata = rd;
    step();                                    // cycle 3
    cnt_ready = 1'b0;
    chk("s_rdy", 32'(req_ready), oh);
    chk("s_err", 32'(req_err), 32'd0);
    chk("s_rd",  req_rdata, rd);
    chk("s_cv3", 32'(cnt_valid), 32'd0);
    req_valid = req_valid & ~NREQ'(oh);
    step();                                    // cycle 4
    chk("s_rdy0", 32'(req_ready), 32'd0);
    chk("s_idle", 32'(busy), 32'd0);
    chk("s_hold", req_rdata, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    logic [31:0] exp_oh;
    reset = 1'b1; req_valid = '0; req_wstrb = '0; req_wdata = '0;
    cnt_ready = 1'b0; cnt_rdata = '0;
    step(); step();
    chk_zero("rst");
    reset = 1'b0;

    // Single request
    single(0, 32'h0000_00A5, 4'hF, 32'h17);

    // Contention from reset: order 0 then 1
    reset = 1'b1; step(); chk_zero("rst2"); reset = 1'b0;
    req_valid = 2'b11; req_wdata = {32'h22, 32'h11}; req_wstrb = 8'h3C;
    step();                                    // c1
    chk("c_gnt0", 32'(grant), 32'd0);
    chk("c_wd0",  cnt_wdata, 32'h11);
    chk("c_ws0",  32'(cnt_wstrb), 32'hC);
    step(); cnt_ready = 1'b1; cnt_rdata = 32'hAA;   // c2
    step(); cnt_ready = 1'b0;                       // c3
    chk("c_rdy3", 32'(req_ready), 32'b01);
    chk("c_rd3",  req_rdata, 32'hAA);
    req_valid = 2'b10;
    step();                                    // c4
    chk("c_rdy4", 32'(req_ready), 32'd0);
    step();                                    // c5
    chk("c_wd5",  cnt_wdata, 32'h22);
    chk("c_gnt5", 32'(grant), 32'd1);
    chk("c_ws5",  32'(cnt_wstrb), 32'h3);
    step(); cnt_ready = 1'b1; cnt_rdata = 32'hBB;   // c6
    step(); cnt_ready = 1'b0;                       // c7
    chk("c_rdy7", 32'(req_ready), 32'b10);
    chk("c_rd7",  req_rdata, 32'hBB);
    req_valid = 2'b00;
    step();

    // Fairness: both held, re-raised one cycle after each ready
    req_valid = 2'b11; req_wdata = {32'h200, 32'h100};
    for (int t = 0; t < 8; t++) begin
      exp_oh = 32'd1 << (t % 2);
      step();
      chk("f_gnt", 32'(grant), 32'(t % 2));
      chk("f_wd",  cnt_wdata, (t % 2 == 0) ? 32'h100 : 32'h200);
      step(); cnt_ready = 1'b1; cnt_rdata = 32'(t);
      step(); cnt_ready = 1'b0;
      chk("f_rdy", 32'(req_ready), exp_oh);
      chk("f_rd",  req_rdata, 32'(t));
      req_valid = req_valid & ~NREQ'(exp_oh);
      step();
      if (t < 7) req_valid = 2'b11;
    end
    req_valid = 2'b00;
    step();

    // Timeout: counter never acks
    req_valid = 2'b01; req_wdata[31:0] = 32'hC0DE;
    n = 0; seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (req_ready != '0) begin seen = 1'b1; break; end
      if (cnt_valid) n++;
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_len",  32'(n), 32'd16);
    chk("to_rdy",  32'(req_ready), 32'b01);
    chk("to_err",  32'(req_err), 32'd1);
    chk("to_rd",   req_rdata, 32'hFFFF_FFFF);
    chk("to_cv",   32'(cnt_valid), 32'd0);
    req_valid = 2'b00;
    step();
    chk("to_err0", 32'(req_err), 32'd0);
    single(1, 32'h3333, 4'h5, 32'h44);

    // Ack on the last timeout cycle wins
    req_valid = 2'b01; req_wdata[31:0] = 32'h99;
    step();                                    // cycle 1
    for (int c = 2; c <= 16; c++) step();      // cycle 16
    chk("col_cv",  32'(cnt_valid), 32'd1);
    chk("col_rdy0", 32'(req_ready), 32'd0);
    cnt_ready = 1'b1; cnt_rdata = 32'h5A5A;
    step(); cnt_ready = 1'b0;
    chk("col_rdy", 32'(req_ready), 32'b01);
    chk("col_err", 32'(req_err), 32'd0);
    chk("col_rd",  req_rdata, 32'h5A5A);
    req_valid = 2'b00;
    step();

    // Reset in cycle 2 of a transaction, then a stale ack
    req_valid = 2'b10; req_wdata[63:32] = 32'h66;
    step();                                    // cycle 1
    chk("r_busy", 32'(busy), 32'd1);
    step(); reset = 1'b1;                      // cycle 2
    step(); reset = 1'b0;                      // cycle 3
    chk_zero("rmid");
    req_valid = 2'b00; cnt_ready = 1'b1; cnt_rdata = 32'h77;
    step(); cnt_ready = 1'b0;
    chk("r_rdy4",  32'(req_ready), 32'd0);
    chk("r_busy4", 32'(busy), 32'd0);
    chk("r_cv4",   32'(cnt_valid), 32'd0);
    chk("r_rd4",   req_rdata, 32'd0);
    step();
    chk("r_rdy5",  32'(req_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
